// File: rtl/regfile16_pkg.sv
// regfile_pkg: shared sizes and dump sequencer state encoding for regfile16.
package regfile_pkg;
  localparam int WIDTH = 16;
  localparam int ADDR_W = 3;
  localparam int NUM_REGS = 1 << ADDR_W;
  typedef enum logic {IDLE, DUMP} dump_state_e;
endpackage

// File: rtl/regfile16_if.sv
// regfile16_if: read, write and dump signals between a regfile16 and its user.
interface regfile16_if
  import regfile_pkg::*;
  ();
  logic [ADDR_W-1:0] read_reg1, read_reg2, write_reg, dump_addr;
  logic [WIDTH-1:0] read_data1, read_data2, write_data, dump_data;
  logic reg_write, dump_req, dump_busy, dump_valid;
  modport master (
    output read_reg1, read_reg2, reg_write, write_reg, write_data, dump_req,
    input read_data1, read_data2, dump_busy, dump_valid, dump_addr, dump_data
  );
  modport slave (
    input read_reg1, read_reg2, reg_write, write_reg, write_data, dump_req,
    output read_data1, read_data2, dump_busy, dump_valid, dump_addr, dump_data
  );
endinterface

// File: rtl/regfile16_dump_fsm.sv
// regfile_dump_fsm: walks idx through every register once per accepted dump request.
module regfile_dump_fsm
  import regfile_pkg::*;
  (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_req_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o
);
  dump_state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  // idx wraps to zero on the final step, so IDLE always holds idx at 0
  always_comb begin
    state_d = (state_q == IDLE) ? (dump_req_i ? DUMP : IDLE) : (&idx_q ? IDLE : DUMP);
    idx_d = (state_q == DUMP) ? idx_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  assign busy_o = (state_q == DUMP);
  assign valid_o = (state_q == DUMP);
  assign addr_o = idx_q;
endmodule

// File: rtl/regfile16.sv
// regfile16: 8x16 register file, r0 hardwired to zero, no write bypass, sequential dump port.
module regfile16 #(
  parameter int WIDTH = regfile_pkg::WIDTH,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input logic clk,
  input logic reset,
  regfile16_if.slave rf
);
  localparam int NUM_REGS = 1 << ADDR_W;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (rf.reg_write && rf.write_reg != '0) begin
      regs_q[rf.write_reg] <= rf.write_data;
    end
  end
  // reads see stored state only, so a same-cycle write never loops back into the ALU
  assign rf.read_data1 = (rf.read_reg1 == '0) ? '0 : regs_q[rf.read_reg1];
  assign rf.read_data2 = (rf.read_reg2 == '0) ? '0 : regs_q[rf.read_reg2];
  assign rf.dump_data = (rf.dump_valid && rf.dump_addr != '0) ? regs_q[rf.dump_addr] : '0;
  regfile_dump_fsm u_dump (
    .clk(clk),
    .reset(reset),
    .dump_req_i(rf.dump_req),
    .busy_o(rf.dump_busy),
    .valid_o(rf.dump_valid),
    .addr_o(rf.dump_addr)
  );
endmodule

// File: tb/tb_regfile16.sv
// tb_regfile16: directed checks of reads, writes, r0, dump sequencing and reset abort.
module tb_regfile16;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  regfile16_if bus ();
  regfile16 dut (.clk(clk), .reset(reset), .rf(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // runs one full dump; a reg5<=BEEF write is issued at address wa, a dump_req pulse at address ra
  task automatic do_dump(input string name, input int wa, input int ra, input logic [15:0] exp5);
    logic [15:0] e;
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    for (int a = 0; a < 8; a++) begin
      if (a == wa) begin
        bus.reg_write = 1'b1;
        bus.write_reg = 3'd5;
        bus.write_data = 16'hBEEF;
      end
      if (a == ra) bus.dump_req = 1'b1;
      #1;
      e = (a == 5) ? exp5 : 16'(a * 16'h0011);
      chk($sformatf("%s_valid%0d", name, a), 32'(bus.dump_valid), 32'd1);
      chk($sformatf("%s_busy%0d", name, a), 32'(bus.dump_busy), 32'd1);
      chk($sformatf("%s_addr%0d", name, a), 32'(bus.dump_addr), 32'(a));
      chk($sformatf("%s_data%0d", name, a), 32'(bus.dump_data), 32'(e));
      tick();
      bus.reg_write = 1'b0;
      bus.dump_req = 1'b0;
    end
    #1;
    chk({name, "_end_busy"}, 32'(bus.dump_busy), 32'd0);
    chk({name, "_end_valid"}, 32'(bus.dump_valid), 32'd0);
    chk({name, "_end_addr"}, 32'(bus.dump_addr), 32'd0);
    chk({name, "_end_data"}, 32'(bus.dump_data), 32'd0);
  endtask
  initial begin
    reset = 1'b1;
    bus.read_reg1 = '0;
    bus.read_reg2 = '0;
    bus.reg_write = 1'b0;
    bus.write_reg = '0;
    bus.write_data = '0;
    bus.dump_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    bus.read_reg1 = 3'd5;
    bus.read_reg2 = 3'd7;
    #1;
    chk("rst_busy", 32'(bus.dump_busy), 32'd0);
    chk("rst_valid", 32'(bus.dump_valid), 32'd0);
    chk("rst_addr", 32'(bus.dump_addr), 32'd0);
    chk("rst_data", 32'(bus.dump_data), 32'd0);
    chk("rst_rd1", 32'(bus.read_data1), 32'd0);
    chk("rst_rd2", 32'(bus.read_data2), 32'd0);
    // write r3 with no bypass: old value this cycle, new value after the edge
    bus.reg_write = 1'b1;
    bus.write_reg = 3'd3;
    bus.write_data = 16'h1234;
    bus.read_reg1 = 3'd3;
    #1;
    chk("nobypass_old", 32'(bus.read_data1), 32'h0000);
    tick();
    bus.reg_write = 1'b0;
    #1;
    chk("nobypass_new", 32'(bus.read_data1), 32'h1234);
    // r0 ignores writes
    bus.reg_write = 1'b1;
    bus.write_reg = 3'd0;
    bus.write_data = 16'hFFFF;
    bus.read_reg1 = 3'd0;
    bus.read_reg2 = 3'd0;
    tick();
    bus.reg_write = 1'b0;
    #1;
    chk("r0_rd1_a", 32'(bus.read_data1), 32'h0000);
    chk("r0_rd2_a", 32'(bus.read_data2), 32'h0000);
    tick();
    chk("r0_rd1_b", 32'(bus.read_data1), 32'h0000);
    chk("r0_rd2_b", 32'(bus.read_data2), 32'h0000);
    for (int i = 1; i < 8; i++) begin
      bus.reg_write = 1'b1;
      bus.write_reg = 3'(i);
      bus.write_data = 16'(i * 16'h0011);
      tick();
    end
    bus.reg_write = 1'b0;
    bus.read_reg1 = 3'd6;
    bus.read_reg2 = 3'd3;
    #1;
    chk("load_rd1", 32'(bus.read_data1), 32'h0066);
    chk("load_rd2", 32'(bus.read_data2), 32'h0033);
    do_dump("plain", -1, -1, 16'h0055);
    // write to the register currently being dumped shows the old value
    do_dump("wr_at5", 5, -1, 16'h0055);
    bus.read_reg1 = 3'd5;
    #1;
    chk("wr_at5_rd", 32'(bus.read_data1), 32'hBEEF);
    bus.reg_write = 1'b1;
    bus.write_reg = 3'd5;
    bus.write_data = 16'h0055;
    tick();
    bus.reg_write = 1'b0;
    // earlier write shows up later in the dump; a mid-dump request must not restart it
    do_dump("wr_at2", 2, 3, 16'hBEEF);
    tick();
    chk("norestart_busy", 32'(bus.dump_busy), 32'd0);
    chk("norestart_valid", 32'(bus.dump_valid), 32'd0);
    // request sampled on the returning edge is dropped
    bus.reg_write = 1'b1;
    bus.write_reg = 3'd5;
    bus.write_data = 16'h0055;
    tick();
    bus.reg_write = 1'b0;
    do_dump("retreq", -1, 7, 16'h0055);
    tick();
    chk("retreq_idle_busy", 32'(bus.dump_busy), 32'd0);
    chk("retreq_idle_valid", 32'(bus.dump_valid), 32'd0);
    // reset mid-dump with a concurrent write to r2
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("abort_addr4", 32'(bus.dump_addr), 32'd4);
    reset = 1'b1;
    bus.reg_write = 1'b1;
    bus.write_reg = 3'd2;
    bus.write_data = 16'hAAAA;
    bus.dump_req = 1'b1;
    tick();
    reset = 1'b0;
    bus.reg_write = 1'b0;
    bus.dump_req = 1'b0;
    bus.read_reg1 = 3'd2;
    bus.read_reg2 = 3'd7;
    #1;
    chk("abort_valid", 32'(bus.dump_valid), 32'd0);
    chk("abort_busy", 32'(bus.dump_busy), 32'd0);
    chk("abort_rd_r2", 32'(bus.read_data1), 32'h0000);
    chk("abort_rd_r7", 32'(bus.read_data2), 32'h0000);
    tick();
    chk("abort_busy_later", 32'(bus.dump_busy), 32'd0);
    chk("abort_r2_later", 32'(bus.read_data1), 32'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
